// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback (port 0) vs.
// long-latency writeback (port 1), plus a busy scoreboard for port-1 destinations.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_data,
  output logic                  p0_ready,
  input  logic                  p1_valid,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_data,
  output logic                  p1_ready,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ok,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  force_p1;
  logic                  p0_fire, p1_fire;

  // Handshake: a port transfers in a cycle iff its valid and ready are both 1
  // at the rising edge; ready depends only on registered state and p0_valid.
  assign force_p1 = (wait_cnt_q >= LIMIT);
  assign p0_ready = !force_p1;
  assign p1_ready = force_p1 || !p0_valid;
  assign p0_fire  = p0_valid && p0_ready;
  assign p1_fire  = p1_valid && p1_ready;

  assign rsv_ok  = !busy_q[rsv_addr];
  assign busy_1  = busy_q[rd_addr_1];
  assign busy_2  = busy_q[rd_addr_2];
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  always_comb begin
    wait_cnt_d = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;

    if (p1_valid && !p1_ready) begin
      wait_cnt_d = force_p1 ? LIMIT : wait_cnt_q + 1'b1;
    end

    // Writes to r0 complete the handshake but never reach the regfile.
    if (p1_fire) begin
      if (p1_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = p1_addr;
        wr_data_d = p1_data;
      end
    end else if (p0_fire) begin
      if (p0_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = p0_addr;
        wr_data_d = p0_data;
      end
    end

    // Clear before set so a same-cycle reservation of the same register wins.
    if (p1_fire) begin
      busy_d[p1_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      busy_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule
